// File: rtl/mac_window_loader_if.sv
// Stream bundle for mac_window_loader.
//   in_data/in_valid/in_ready : serial pixel input (valid/ready)
//   pixels/pix_valid/pix_ready: packed window output to the MAC pixel bus
// master = the loader side, slave = the producer/consumer environment.
interface mac_window_loader_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned NPIX  = 16
);
  logic [PIX_W-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [NPIX*PIX_W-1:0] pixels;
  logic                  pix_valid;
  logic                  pix_ready;

  modport master (
    input  in_data, in_valid, pix_ready,
    output in_ready, pixels, pix_valid
  );

  modport slave (
    output in_data, in_valid, pix_ready,
    input  in_ready, pixels, pix_valid
  );
endinterface

// File: rtl/mac_window_loader.sv
// Packs a serial pixel stream into NPIX-pixel windows for the MAC datapath.
// The fill buffer collects the next window while the output word is held, so
// a consumer that keeps up sees one pixel per clock of throughput.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush of fill buffer and output word
//   bus         : pixel input and window output handshakes (master modport)
//   fill_level  : pixels currently in the fill buffer (0..NPIX)
//   win_count   : windows delivered, wraps at 2^COUNT_W
module mac_window_loader #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned NPIX    = 16,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  mac_window_loader_if.master    bus,
  output logic [4:0]             fill_level,
  output logic [COUNT_W-1:0]     win_count
);

  localparam int unsigned WIN_W = NPIX * PIX_W;
  localparam int unsigned CNT_W = 5;

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] fill_q;
  logic [WIN_W-1:0] window_c;
  logic [WIN_W-1:0] pixels_q;
  logic             pix_valid_q, pix_valid_d;
  logic             accept_c, take_c, load_c, wr_c;

  assign bus.in_ready  = (state_q == FILL);
  assign accept_c      = bus.in_valid && bus.in_ready;
  assign take_c        = pix_valid_q && bus.pix_ready;
  assign bus.pixels    = pixels_q;
  assign bus.pix_valid = pix_valid_q;
  assign fill_level    = cnt_q;

  // Fill buffer with the byte being accepted merged in, first pixel in the MSBs.
  always_comb begin
    window_c = fill_q;
    if (accept_c) begin
      window_c[WIN_W - 1 - PIX_W * 32'(cnt_q) -: PIX_W] = bus.in_data;
    end
  end

  // Next-state / control decode; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pix_valid_d = pix_valid_q;
    load_c      = 1'b0;
    wr_c        = 1'b0;
    if (clear) begin
      state_d     = FILL;
      cnt_d       = '0;
      pix_valid_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (take_c) pix_valid_d = 1'b0;
          if (accept_c) begin
            wr_c = 1'b1;
            if (cnt_q == CNT_W'(NPIX - 1)) begin
              // Output free now (empty or being taken): hand over with no bubble.
              if (!pix_valid_q || bus.pix_ready) begin
                load_c      = 1'b1;
                pix_valid_d = 1'b1;
                cnt_d       = '0;
              end else begin
                state_d = HOLD;
                cnt_d   = CNT_W'(NPIX);
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (take_c) begin
            load_c      = 1'b1;
            pix_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Datapath and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      fill_q      <= '0;
      pixels_q    <= '0;
      pix_valid_q <= 1'b0;
      win_count   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pix_valid_q <= pix_valid_d;
      if (wr_c) fill_q <= window_c;
      if (clear)       pixels_q <= '0;
      else if (load_c) pixels_q <= window_c;
      if (take_c && !clear) win_count <= win_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mac_window_loader.sv
// Directed bench for mac_window_loader: reset, packing, backpressure,
// zero-bubble handover, clear, and counter wrap (second instance, COUNT_W=4).
module tb_mac_window_loader;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        clear4;
  logic [4:0]  fill_level;
  logic [15:0] win_count;
  logic [4:0]  fill_level4;
  logic [3:0]  win_count4;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] W_01 = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] W_00 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] W_10 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] W_30 = 128'h303132333435363738393A3B3C3D3E3F;
  localparam logic [127:0] W_A0 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;

  mac_window_loader_if #(.PIX_W(8), .NPIX(16)) bus ();
  mac_window_loader_if #(.PIX_W(8), .NPIX(16)) bus4 ();

  mac_window_loader #(.PIX_W(8), .NPIX(16), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .fill_level(fill_level), .win_count(win_count)
  );

  mac_window_loader #(.PIX_W(8), .NPIX(16), .COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .bus(bus4),
    .fill_level(fill_level4), .win_count(win_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int stalls;
    logic acc;

    rst_n = 1'b0;
    clear = 1'b0;
    clear4 = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.pix_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.pix_ready = 1'b0;

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check("por_pix_valid", 128'(bus.pix_valid), 128'(0));
    check("por_pixels", bus.pixels, 128'(0));
    check("por_fill_level", 128'(fill_level), 128'(0));
    check("por_win_count", 128'(win_count), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    step();
    check("por_in_ready", 128'(bus.in_ready), 128'(1));

    // T2: basic window, consumer ready
    bus.pix_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data  = 8'(i + 1);
      bus.in_valid = 1'b1;
      if (i == 15) check("t2_valid_before_last", 128'(bus.pix_valid), 128'(0));
      step();
    end
    check("t2_pix_valid", 128'(bus.pix_valid), 128'(1));
    check("t2_pixels", bus.pixels, W_01);
    check("t2_win_count_pre", 128'(win_count), 128'(0));
    bus.in_valid = 1'b0;
    step();
    check("t2_valid_drop", 128'(bus.pix_valid), 128'(0));
    check("t2_win_count", 128'(win_count), 128'(1));

    // T1: async reset mid-window
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_data  = 8'(8'h50 + i);
      bus.in_valid = 1'b1;
      step();
    end
    check("t1_fill_level_7", 128'(fill_level), 128'(7));
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t1_pixels", bus.pixels, 128'(0));
    check("t1_pix_valid", 128'(bus.pix_valid), 128'(0));
    check("t1_fill_level", 128'(fill_level), 128'(0));
    check("t1_win_count", 128'(win_count), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    step();
    check("t1_in_ready", 128'(bus.in_ready), 128'(1));

    // T3: backpressure, 40 bytes offered
    bus.pix_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      bus.in_data  = 8'(idx);
      bus.in_valid = 1'b1;
      acc = bus.in_ready;
      step();
      if (acc) idx++;
    end
    check("t3_accepted", 128'(idx), 128'(32));
    check("t3_in_ready", 128'(bus.in_ready), 128'(0));
    check("t3_fill_level", 128'(fill_level), 128'(16));
    check("t3_pixels_w0", bus.pixels, W_00);
    check("t3_pix_valid", 128'(bus.pix_valid), 128'(1));
    bus.pix_ready = 1'b1;
    bus.in_data   = 8'(idx);
    step();
    check("t3_pixels_w1", bus.pixels, W_10);
    check("t3_valid_w1", 128'(bus.pix_valid), 128'(1));
    check("t3_in_ready_back", 128'(bus.in_ready), 128'(1));
    check("t3_win_count_1", 128'(win_count), 128'(1));
    step();
    check("t3_valid_drop", 128'(bus.pix_valid), 128'(0));
    check("t3_fill_after", 128'(fill_level), 128'(1));
    check("t3_win_count_2", 128'(win_count), 128'(2));
    bus.in_valid  = 1'b0;
    bus.pix_ready = 1'b0;

    // T4: zero-bubble handover while streaming 64 bytes
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4_clear_fill", 128'(fill_level), 128'(0));
    check("t4_clear_count", 128'(win_count), 128'(2));
    stalls = 0;
    for (int e = 0; e <= 64; e++) begin
      bus.in_valid  = (e < 64);
      bus.in_data   = 8'(e);
      bus.pix_ready = (e >= 31);
      if (e < 64 && !bus.in_ready) stalls++;
      if (e == 31) check("t4_pre_pixels", bus.pixels, W_00);
      step();
      if (e == 31) begin
        check("t4_valid_kept", 128'(bus.pix_valid), 128'(1));
        check("t4_new_window", bus.pixels, W_10);
        check("t4_no_hold", 128'(bus.in_ready), 128'(1));
        check("t4_count_3", 128'(win_count), 128'(3));
      end
    end
    check("t4_stalls", 128'(stalls), 128'(0));
    check("t4_count_6", 128'(win_count), 128'(6));
    check("t4_valid_end", 128'(bus.pix_valid), 128'(0));

    // T5: clear with partial window and a pending output window
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 23; i++) begin
      bus.in_data  = 8'(8'h30 + i);
      bus.in_valid = 1'b1;
      step();
    end
    check("t5_pending", bus.pixels, W_30);
    check("t5_partial", 128'(fill_level), 128'(7));
    clear         = 1'b1;
    bus.in_data   = 8'hEE;
    bus.in_valid  = 1'b1;
    bus.pix_ready = 1'b1;
    step();
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pix_ready = 1'b0;
    check("t5_fill_level", 128'(fill_level), 128'(0));
    check("t5_pix_valid", 128'(bus.pix_valid), 128'(0));
    check("t5_pixels", bus.pixels, 128'(0));
    check("t5_win_count", 128'(win_count), 128'(6));
    for (int i = 0; i < 16; i++) begin
      bus.in_data  = 8'(8'hA0 + i);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    check("t5_window_a0", bus.pixels, W_A0);
    check("t5_valid_a0", 128'(bus.pix_valid), 128'(1));
    bus.pix_ready = 1'b1;
    step();
    check("t5_win_count_7", 128'(win_count), 128'(7));
    bus.pix_ready = 1'b0;

    // T6: 4-bit counter wraps after 16 windows
    bus4.pix_ready = 1'b1;
    for (int e = 0; e <= 272; e++) begin
      bus4.in_valid = (e < 272);
      bus4.in_data  = 8'(e);
      step();
      if (e == 256) check("t6_wrap_zero", 128'(win_count4), 128'(0));
    end
    check("t6_win_count", 128'(win_count4), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
